muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; legal values are even and at least 4.
REQ-002 SHALL have parameter CW, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand or dividend (rs).
REQ-008 SHALL have port b, input, WIDTH bits: multiplier or divisor (rt).
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of the current operation.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port div0, output, 1 bit: divide-by-zero flag, valid while done is high.
REQ-013 SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-014 SHALL have port lo, output, WIDTH bits: product lower half, or quotient.
REQ-015 SHALL have port counter, output, CW bits: remaining iterations, for debug.

Function
REQ-016 SHALL implement FSM states IDLE, PREP, RUN, FIX and DONE.
REQ-017 SHALL accept start&&!abort in IDLE: latch a, b and op, then go to PREP.
REQ-018 In PREP, signed ops SHALL take operand magnitudes and record result signs; counter SHALL load WIDTH.
REQ-019 In PREP, DIV/DIVU with b==0 SHALL go directly to DONE with div0=1 and hi/lo unchanged.
REQ-020 RUN SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-021 RUN SHALL decrement counter each cycle and exit to FIX when counter reaches 0, giving exactly WIDTH RUN cycles.
REQ-022 FIX SHALL apply signs:
- product negated when operand signs differ;
- quotient negated when signs differ;
- remainder takes the dividend's sign.
REQ-023 FIX SHALL then write hi/lo; hi/lo SHALL otherwise hold their value.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be fixed: done is high in the cycle after the (WIDTH+2)th rising edge following the accepting edge, or after the 2nd edge for div0.
REQ-026 Multiply results SHALL be exact 2·WIDTH-bit values in {hi,lo}; unsigned multiply SHALL not overflow.
REQ-027 Division SHALL truncate toward zero.
REQ-028 DIV of the most-negative value by -1 SHALL give lo=most-negative and hi=0, with no flag.
REQ-029 start while busy SHALL be ignored, with no queuing.
REQ-030 abort SHALL return the FSM to IDLE on the next edge from any state, with no done pulse and hi/lo unchanged; abort outranks start.
REQ-031 div0 SHALL clear on the next accepted start.

Reset
REQ-032 Reset low SHALL immediately force state=IDLE, hi=0, lo=0, counter=0, done=0, div0=0 and busy=0.
REQ-033 Reset mid-operation SHALL discard the operation; no done SHALL follow reset release.

Structure
REQ-034 The op encodings and the FSM state enum SHALL live in the shared package muldiv_pkg.
REQ-035 Two's-complement magnitude/negate SHALL be sub-module muldiv_abs (parameter WIDTH), instantiated for operands and results.
REQ-036 The datapath SHALL use one 2·WIDTH+1-bit accumulator shared by multiply and divide; no combinational array multiplier or divider.

Verification
REQ-037 WIDTH=32, MULT a=0xFFFFFFFF, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9; done exactly 34 edges after start.
REQ-038 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIVU a=100, b=0 -> done and div0 high 2 edges after start; hi/lo retain the previous result.
REQ-041 start pulsed in RUN -> ignored, first result unaffected; abort in RUN -> IDLE next edge, no done, hi/lo unchanged.
REQ-042 reset low mid-RUN -> outputs 0 asynchronously; after release, no done until a new start.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state encoding and op decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation select encodings (op port)
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_abs.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_abs
// Description : Conditional two's-complement negation. Used both to take the
//               magnitude of signed operands and to re-apply result signs.
// Ports       : i_value  - input word
//               i_negate - 1: output is -i_value, 0: output is i_value
//               o_result - (possibly negated) word
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply / divide unit (MULT, MULTU, DIV,
//               DIVU). Signed operations work on magnitudes and fix signs at
//               the end. One shared 2*WIDTH+1 bit accumulator serves both
//               shift-add multiply and restoring shift-subtract divide.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous active-low reset
//               start   - operation request (sampled in IDLE only)
//               op      - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               a, b    - multiplicand/dividend, multiplier/divisor
//               abort   - cancel current operation (outranks start)
//               busy    - high outside IDLE
//               done    - one-cycle completion pulse
//               div0    - divide by zero flag, valid with done
//               hi, lo  - product high/low, or remainder/quotient
//               counter - remaining iterations (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CW-1:0]    counter
);

    state_e                 r_state;
    state_e                 w_next;

    logic [1:0]             r_op;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH:0]       r_acc;
    logic                   r_neg_res;   // product / quotient sign
    logic                   r_neg_rem;   // remainder sign (dividend sign)
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_div0;

    logic                   w_signed;
    logic                   w_is_div;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic                   w_b_zero;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;

    logic [WIDTH:0]         w_mul_add;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH:0]       w_mul_next;
    logic [2*WIDTH:0]       w_div_sh;
    logic [WIDTH:0]         w_div_diff;
    logic [2*WIDTH:0]       w_div_next;

    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;

    // ------------------------------------------------------------------
    // Operand decode and magnitudes (from latched operands)
    // ------------------------------------------------------------------
    assign w_signed = op_is_signed(r_op);
    assign w_is_div = op_is_div(r_op);
    assign w_a_neg  = w_signed & r_a[WIDTH-1];
    assign w_b_neg  = w_signed & r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_value  (r_a),
        .i_negate (w_a_neg),
        .o_result (w_a_mag)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_value  (r_b),
        .i_negate (w_b_neg),
        .o_result (w_b_mag)
    );

    // ------------------------------------------------------------------
    // One iteration of each algorithm on the shared accumulator.
    // Multiply: acc = {0, partial[W-1:0], multiplier}; add on LSB, shift right.
    // Divide  : acc = {rem[W:0], dividend}; shift left, trial subtract.
    // W+1 bits suffice for the trial difference: its MSB is the borrow.
    // ------------------------------------------------------------------
    assign w_mul_add  = r_acc[0] ? {1'b0, r_opnd} : '0;
    assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + w_mul_add;
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

    assign w_div_sh   = {r_acc[2*WIDTH-1:0], 1'b0};
    assign w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_opnd};
    assign w_div_next = w_div_diff[WIDTH] ? w_div_sh
                                          : {w_div_diff, w_div_sh[WIDTH-1:1], 1'b1};

    // ------------------------------------------------------------------
    // Sign fix-up of the final magnitudes
    // ------------------------------------------------------------------
    muldiv_abs #(.WIDTH(2*WIDTH)) u_abs_prod (
        .i_value  (r_acc[2*WIDTH-1:0]),
        .i_negate (r_neg_res),
        .o_result (w_prod)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_quo (
        .i_value  (r_acc[WIDTH-1:0]),
        .i_negate (r_neg_res),
        .o_result (w_quo)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .i_value  (r_acc[2*WIDTH-1:WIDTH]),
        .i_negate (r_neg_rem),
        .o_result (w_rem)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_next = ST_PREP;
                // A zero divisor bypasses the iterations; passing through FIX
                // (which then writes nothing) keeps div0 latency at two edges.
                ST_PREP: w_next = (w_is_div && w_b_zero) ? ST_FIX : ST_RUN;
                // Counter hits zero on the same edge that leaves RUN.
                ST_RUN:  if (r_count == CW'(1)) w_next = ST_FIX;
                ST_FIX:  w_next = ST_DONE;
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers. Nothing updates in a cycle where abort is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_div0    <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_op   <= op;
                        r_div0 <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_count   <= CW'(WIDTH);
                    if (w_is_div) begin
                        r_acc  <= {{(WIDTH+1){1'b0}}, w_a_mag};
                        r_opnd <= w_b_mag;
                        r_div0 <= w_b_zero;
                    end else begin
                        r_acc  <= {{(WIDTH+1){1'b0}}, w_b_mag};
                        r_opnd <= w_a_mag;
                    end
                end
                ST_RUN: begin
                    r_count <= r_count - CW'(1);
                    r_acc   <= w_is_div ? w_div_next : w_mul_next;
                end
                ST_FIX: begin
                    if (!r_div0) begin
                        if (w_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign div0    = r_div0;
    assign counter = r_count;

endmodule
`default_nettype wire
